// File: rtl/riscv_core_dpath_vector_regfile_lanes_pkg.sv
// Shared types and helpers for the multi-lane vector register file.
// Holds the clear-engine state encoding and width/lane helpers.
package riscv_vrf_pkg;

  typedef enum logic [1:0] {
    CLR_ALL,
    IDLE,
    CLR_ONE
  } vrf_state_e;

  function automatic int unsigned bits_for(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int lane_lo(input int lane, input int dw);
    return lane * dw;
  endfunction

endpackage

// File: rtl/riscv_core_dpath_vector_regfile_lanes_if.sv
// Issue-stage <-> vector register file bundle.
// Read/write ports, clear request and ready/done handshake.
interface riscv_core_dpath_vector_regfile_lanes_if #(
  parameter int unsigned NUM_VREGS = 32,
  parameter int unsigned VLEN = 64,
  parameter int unsigned LANES = 4,
  parameter int unsigned DW = 32
);
  import riscv_vrf_pkg::*;

  localparam int unsigned AW = bits_for(NUM_VREGS);
  localparam int unsigned IW = bits_for(VLEN);
  localparam int unsigned LW = bits_for(LANES);

  logic [AW-1:0] v_raddr0;
  logic [IW-1:0] v_ridx0;
  logic [LANES*DW-1:0] v_rdata0;
  logic [AW-1:0] v_raddr1;
  logic [IW-1:0] v_ridx1;
  logic [LANES*DW-1:0] v_rdata1;
  logic v_wen_p;
  logic [AW-1:0] v_waddr_p;
  logic [IW-1:0] v_widx_p;
  logic [LW-1:0] v_lanes;
  logic [LANES-1:0] v_wmask;
  logic [LANES*DW-1:0] v_wdata_p;
  logic clr_req;
  logic [AW-1:0] clr_addr;
  logic v_ready;
  logic clr_done;

  modport master (
    output v_raddr0, v_ridx0, v_raddr1, v_ridx1,
    output v_wen_p, v_waddr_p, v_widx_p, v_lanes,
    output v_wmask, v_wdata_p, clr_req, clr_addr,
    input v_rdata0, v_rdata1, v_ready, clr_done
  );

  modport slave (
    input v_raddr0, v_ridx0, v_raddr1, v_ridx1,
    input v_wen_p, v_waddr_p, v_widx_p, v_lanes,
    input v_wmask, v_wdata_p, clr_req, clr_addr,
    output v_rdata0, v_rdata1, v_ready, clr_done
  );

endinterface

// File: rtl/riscv_core_dpath_vector_regfile_lanes_clear_fsm.sv
// Clear engine: full sweep after reset, single-register clear on request.
// Drives the chunk being zeroed plus registered ready/done.
module riscv_vrf_clear_fsm
  import riscv_vrf_pkg::*;
#(
  parameter int unsigned NUM_VREGS = 32,
  parameter int unsigned CHUNKS = 16,
  localparam int unsigned AW = bits_for(NUM_VREGS),
  localparam int unsigned CW = bits_for(CHUNKS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_req,
  input  logic [AW-1:0] clr_addr,
  output logic          clr_en,
  output logic [AW-1:0] clr_reg,
  output logic [CW-1:0] clr_chunk,
  output logic          v_ready,
  output logic          clr_done
);

  vrf_state_e state;
  logic [AW-1:0] reg_cnt;
  logic [AW-1:0] addr_q;
  logic [CW-1:0] chunk_cnt;
  logic last_chunk;
  logic last_reg;

  assign last_chunk = chunk_cnt == CW'(CHUNKS - 1);
  assign last_reg = reg_cnt == AW'(NUM_VREGS - 1);
  assign clr_en = state != IDLE;
  assign clr_reg = (state == CLR_ALL) ? reg_cnt : addr_q;
  assign clr_chunk = chunk_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLR_ALL;
      reg_cnt <= '0;
      chunk_cnt <= '0;
      addr_q <= '0;
      v_ready <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      unique case (state)
        CLR_ALL: begin
          if (last_chunk) begin
            chunk_cnt <= '0;
            if (last_reg) begin
              reg_cnt <= '0;
              state <= IDLE;
              v_ready <= 1'b1;
              clr_done <= 1'b1;
            end else begin
              reg_cnt <= reg_cnt + 1'b1;
            end
          end else begin
            chunk_cnt <= chunk_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (clr_req) begin
            addr_q <= clr_addr;
            chunk_cnt <= '0;
            state <= CLR_ONE;
            v_ready <= 1'b0;
          end
        end
        CLR_ONE: begin
          if (last_chunk) begin
            chunk_cnt <= '0;
            state <= IDLE;
            v_ready <= 1'b1;
            clr_done <= 1'b1;
          end else begin
            chunk_cnt <= chunk_cnt + 1'b1;
          end
        end
        default: state <= CLR_ALL;
      endcase
    end
  end

endmodule

// File: rtl/riscv_core_dpath_vector_regfile_lanes.sv
// Multi-lane vector register file: two wrapping read ports, one masked
// write port with optional write-to-read bypass, sequential clear engine.
module riscv_core_dpath_vector_regfile_lanes
  import riscv_vrf_pkg::*;
#(
  parameter int unsigned NUM_VREGS = 32,
  parameter int unsigned VLEN = 64,
  parameter int unsigned LANES = 4,
  parameter int unsigned DW = 32,
  parameter bit BYPASS = 1'b1
) (
  input logic clk,
  input logic reset,
  riscv_core_dpath_vector_regfile_lanes_if.slave vif
);

  localparam int unsigned AW = bits_for(NUM_VREGS);
  localparam int unsigned IW = bits_for(VLEN);
  localparam int unsigned LW = bits_for(LANES);
  localparam int unsigned CHUNKS = VLEN / LANES;
  localparam int unsigned CW = bits_for(CHUNKS);

  logic [DW-1:0] arr [NUM_VREGS][VLEN];
  logic clr_en;
  logic [AW-1:0] clr_reg;
  logic [CW-1:0] clr_chunk;
  logic ready;
  logic done;
  logic [AW-1:0] waddr;
  logic [LANES*DW-1:0] wdata;
  logic [LANES-1:0] w_en;
  logic [IW-1:0] w_idx [LANES];
  logic [LANES*DW-1:0] rdata0;
  logic [LANES*DW-1:0] rdata1;

  riscv_vrf_clear_fsm #(
    .NUM_VREGS(NUM_VREGS),
    .CHUNKS(CHUNKS)
  ) u_clr (
    .clk(clk),
    .reset(reset),
    .clr_req(vif.clr_req),
    .clr_addr(vif.clr_addr),
    .clr_en(clr_en),
    .clr_reg(clr_reg),
    .clr_chunk(clr_chunk),
    .v_ready(ready),
    .clr_done(done)
  );

  assign vif.v_ready = ready;
  assign vif.clr_done = done;
  assign waddr = vif.v_waddr_p;
  assign wdata = vif.v_wdata_p;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_idx[i] = vif.v_widx_p + IW'(i);
      w_en[i] = vif.v_wen_p && ready
        && (LW'(i) <= vif.v_lanes) && vif.v_wmask[i];
    end
  end

  for (genvar r = 0; r < NUM_VREGS; r++) begin : g_reg
    for (genvar e = 0; e < VLEN; e++) begin : g_elem
      logic we;
      logic [DW-1:0] wd;
      logic [DW-1:0] q;
      always_comb begin
        we = clr_en && clr_reg == AW'(r)
          && clr_chunk == CW'(e / LANES);
        wd = '0;
        for (int j = 0; j < LANES; j++) begin
          if (w_en[j] && waddr == AW'(r) && w_idx[j] == IW'(e)) begin
            we = 1'b1;
            wd = wdata[lane_lo(j, DW) +: DW];
          end
        end
      end
      always_ff @(posedge clk) begin
        if (we) q <= wd;
      end
      assign arr[r][e] = q;
    end
  end

  // Clear writes are never forwarded: only the user write port bypasses.
  function automatic logic [LANES*DW-1:0] rd_port(
    input logic [AW-1:0] a,
    input logic [IW-1:0] s
  );
    logic [LANES*DW-1:0] d;
    logic [IW-1:0] e;
    d = '0;
    for (int i = 0; i < LANES; i++) begin
      e = s + IW'(i);
      d[lane_lo(i, DW) +: DW] = arr[a][e];
      for (int j = 0; j < LANES; j++) begin
        if (BYPASS && w_en[j] && waddr == a && w_idx[j] == e)
          d[lane_lo(i, DW) +: DW] = wdata[lane_lo(j, DW) +: DW];
      end
    end
    return d;
  endfunction

  always_comb begin
    rdata0 = rd_port(vif.v_raddr0, vif.v_ridx0);
    rdata1 = rd_port(vif.v_raddr1, vif.v_ridx1);
  end

  assign vif.v_rdata0 = rdata0;
  assign vif.v_rdata1 = rdata1;

endmodule

// File: tb/tb_riscv_core_dpath_vector_regfile_lanes.sv
// Scoreboard bench for the vector register file: sweep, wrap/masked
// writes, bypass, single-register clear and reset during a sweep.
module tb_riscv_core_dpath_vector_regfile_lanes;
  import riscv_vrf_pkg::*;

  localparam int unsigned NV = 4;
  localparam int unsigned VL = 8;
  localparam int unsigned LN = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = bits_for(NV);
  localparam int unsigned IW = bits_for(VL);
  localparam int unsigned LW = bits_for(LN);
  localparam int unsigned W = LN * DW;

  logic clk = 1'b0;
  logic reset = 1'b1;

  riscv_core_dpath_vector_regfile_lanes_if #(
    .NUM_VREGS(NV), .VLEN(VL), .LANES(LN), .DW(DW)
  ) vif ();

  riscv_core_dpath_vector_regfile_lanes #(
    .NUM_VREGS(NV), .VLEN(VL), .LANES(LN), .DW(DW), .BYPASS(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .vif(vif)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] m [NV][VL];
  logic [W-1:0] exp_q [$];
  string tag_q [$];
  int n_cmp = 0;
  int n_err = 0;
  int done_seen = 0;

  always @(negedge clk) if (vif.clr_done === 1'b1) done_seen++;

  task automatic chk(input string tag, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mrd(input int a, input int s);
    logic [W-1:0] r;
    for (int i = 0; i < LN; i++) r[i*DW +: DW] = m[a][(s + i) % VL];
    return r;
  endfunction

  function automatic logic [W-1:0] brd(input int a, input int s,
      input int wa, input int ws, input int nl,
      input logic [LN-1:0] mk, input logic [W-1:0] wd);
    logic [W-1:0] r;
    r = mrd(a, s);
    for (int i = 0; i < LN; i++)
      for (int j = 0; j < LN; j++)
        if (a == wa && j <= nl && mk[j] && (ws + j) % VL == (s + i) % VL)
          r[i*DW +: DW] = wd[j*DW +: DW];
    return r;
  endfunction

  task automatic mwr(input int a, input int s, input int nl,
                     input logic [LN-1:0] mk, input logic [W-1:0] wd);
    for (int j = 0; j < LN; j++)
      if (j <= nl && mk[j]) m[a][(s + j) % VL] = wd[j*DW +: DW];
  endtask

  task automatic mclr(input int a);
    for (int e = 0; e < VL; e++) m[a][e] = '0;
  endtask

  task automatic drive_w(input int a, input int s, input int nl,
                         input logic [LN-1:0] mk, input logic [W-1:0] wd);
    vif.v_wen_p = 1'b1;
    vif.v_waddr_p = AW'(a);
    vif.v_widx_p = IW'(s);
    vif.v_lanes = LW'(nl);
    vif.v_wmask = mk;
    vif.v_wdata_p = wd;
  endtask

  task automatic wr(input int a, input int s, input int nl,
                    input logic [LN-1:0] mk, input logic [W-1:0] wd);
    @(negedge clk);
    drive_w(a, s, nl, mk, wd);
    mwr(a, s, nl, mk, wd);
    @(negedge clk);
    vif.v_wen_p = 1'b0;
  endtask

  task automatic rd2(input string tag, input int a0, input int s0,
                     input int a1, input int s1,
                     input logic [W-1:0] e0, input logic [W-1:0] e1);
    vif.v_raddr0 = AW'(a0);
    vif.v_ridx0 = IW'(s0);
    vif.v_raddr1 = AW'(a1);
    vif.v_ridx1 = IW'(s1);
    exp_q.push_back(e0);
    tag_q.push_back({tag, "_p0"});
    exp_q.push_back(e1);
    tag_q.push_back({tag, "_p1"});
    #1;
    chk(tag_q.pop_front(), vif.v_rdata0, exp_q.pop_front());
    chk(tag_q.pop_front(), vif.v_rdata1, exp_q.pop_front());
  endtask

  task automatic wait_ready(output int busy);
    busy = 0;
    while (!vif.v_ready && busy < 40) begin
      busy++;
      @(negedge clk);
    end
  endtask

  task automatic zero_all(input string tag);
    for (int r = 0; r < NV; r++) begin
      @(negedge clk);
      rd2(tag, r, 0, r, 4, mrd(r, 0), mrd(r, 4));
    end
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: n_cmp %0d", n_cmp);
    $fatal(1, "timeout");
  end

  int busy;
  int d0;
  logic [W-1:0] e0, e1;
  logic [W-1:0] bw;

  initial begin
    vif.v_raddr0 = '0; vif.v_ridx0 = '0;
    vif.v_raddr1 = '0; vif.v_ridx1 = '0;
    vif.v_wen_p = 1'b0; vif.v_waddr_p = '0; vif.v_widx_p = '0;
    vif.v_lanes = '0; vif.v_wmask = '0; vif.v_wdata_p = '0;
    vif.clr_req = 1'b0; vif.clr_addr = '0;
    for (int r = 0; r < NV; r++) mclr(r);

    // power-up sweep
    @(negedge clk);
    reset = 1'b0;
    wait_ready(busy);
    chk("sweep_busy", W'(busy), W'(8));
    chk("sweep_done", W'(vif.clr_done), W'(1));
    @(negedge clk);
    chk("done_drop", W'(vif.clr_done), W'(0));
    zero_all("zero");

    // wrapping write
    wr(2, 6, 3, 4'hF, {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001});
    rd2("wrap", 2, 6, 2, 0,
        {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001}, mrd(2, 0));

    // masked partial write
    wr(2, 0, 1, 4'b0010, {32'h3, 32'h2, 32'hEEEE0001, 32'h0});
    rd2("part", 2, 0, 2, 4, mrd(2, 0), mrd(2, 4));

    // lane-count limit with full mask
    wr(0, 3, 1, 4'hF, {32'h44, 32'h43, 32'h42, 32'h41});
    rd2("lanes", 0, 0, 0, 4, mrd(0, 0), mrd(0, 4));

    // bypass
    wr(1, 0, 3, 4'hF, {32'd4, 32'd3, 32'd2, 32'd1});
    @(negedge clk);
    bw = {32'd44, 32'd33, 32'd22, 32'd11};
    drive_w(1, 2, 3, 4'hF, bw);
    e0 = brd(1, 0, 1, 2, 3, 4'hF, bw);
    e1 = brd(1, 4, 1, 2, 3, 4'hF, bw);
    rd2("byp", 1, 0, 1, 4, e0, e1);
    mwr(1, 2, 3, 4'hF, bw);
    @(negedge clk);
    vif.v_wen_p = 1'b0;
    rd2("byp_commit", 1, 0, 1, 4, mrd(1, 0), mrd(1, 4));

    // masked-off lanes and other registers are not forwarded
    @(negedge clk);
    bw = {32'd8, 32'd7, 32'd6, 32'd5};
    drive_w(1, 0, 3, 4'b0101, bw);
    e0 = brd(1, 0, 1, 0, 3, 4'b0101, bw);
    e1 = brd(2, 0, 1, 0, 3, 4'b0101, bw);
    rd2("byp_mask", 1, 0, 2, 0, e0, e1);
    mwr(1, 0, 3, 4'b0101, bw);
    @(negedge clk);
    vif.v_wen_p = 1'b0;
    rd2("mask_commit", 1, 0, 1, 4, mrd(1, 0), mrd(1, 4));

    // single-register clear with a same-cycle write
    @(negedge clk);
    vif.clr_req = 1'b1;
    vif.clr_addr = AW'(2);
    drive_w(3, 0, 3, 4'hF, {32'h3333, 32'h2222, 32'h1111, 32'h0000FFFF});
    mwr(3, 0, 3, 4'hF, {32'h3333, 32'h2222, 32'h1111, 32'h0000FFFF});
    @(negedge clk);
    vif.clr_addr = AW'(1);
    drive_w(0, 0, 3, 4'hF, {4{32'hDEADBEEF}});
    busy = 0;
    while (!vif.v_ready && busy < 40) begin
      busy++;
      @(negedge clk);
      vif.clr_req = 1'b0;
      vif.v_wen_p = 1'b0;
    end
    vif.clr_req = 1'b0;
    vif.v_wen_p = 1'b0;
    mclr(2);
    chk("clr_busy", W'(busy), W'(2));
    chk("clr_done", W'(vif.clr_done), W'(1));
    rd2("clr_reg2", 2, 0, 2, 4, mrd(2, 0), mrd(2, 4));
    @(negedge clk);
    chk("clr_done_drop", W'(vif.clr_done), W'(0));
    rd2("clr_keep", 3, 0, 0, 0, mrd(3, 0), mrd(0, 0));
    @(negedge clk);
    rd2("clr_ign", 1, 0, 1, 4, mrd(1, 0), mrd(1, 4));

    // reset in the middle of the sweep
    @(negedge clk);
    reset = 1'b1;
    d0 = done_seen;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", W'(vif.v_ready), W'(0));
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_ready(busy);
    chk("rst_busy", W'(busy), W'(8));
    chk("rst_done", W'(vif.clr_done), W'(1));
    repeat (3) @(negedge clk);
    chk("rst_one_done", W'(done_seen - d0), W'(1));
    for (int r = 0; r < NV; r++) mclr(r);
    zero_all("rst_zero");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
